// File: rtl/uart_rx_fifo_if.sv
// Byte-stream interface between the UART receiver/FIFO and its consumer.
// master = receiver side (drives head byte and status), slave = consumer side (drives line and pop).
interface uart_rx_fifo_if #(
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic              rxd;
   logic              rd_en;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [FILL_W-1:0] fill;
   logic              frame_err;
   logic              parity_err;
   logic              overflow;

   modport master (
      input  rxd, rd_en,
      output rx_data, rx_valid, fill, frame_err, parity_err, overflow
   );

   modport slave (
      output rxd, rd_en,
      input  rx_data, rx_valid, fill, frame_err, parity_err, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word-fall-through byte FIFO with framing/parity/overflow reporting.
module uart_rx_fifo #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic           clk100,
   input  logic           rst,
   uart_rx_fifo_if.master bus
);
   localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned FILL_W  = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   logic             r_rx_meta, r_rxs;
   logic [DIV_W-1:0] r_div;
   logic             w_tick;
   state_t           r_state;
   logic [3:0]       r_samp;
   logic             r_s7, r_s8;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_frame_err;
   logic             w_vote, w_at_vote, w_par_bad, w_push;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [AW:0]       r_wptr, r_rptr;
   logic [AW:0]       w_rptr_next;
   logic [FILL_W-1:0] r_fill, w_fill_next;
   logic              r_valid, r_overflow;
   logic [7:0]        r_rx_data;
   logic              w_empty, w_full, w_pop, w_wr;

   // Line synchronizer; resets to the idle level
   always_ff @(posedge clk100) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= bus.rxd;
         r_rxs     <= r_rx_meta;
      end
   end

   assign w_tick = (r_div == DIV_W'(DIV - 1));

   always_ff @(posedge clk100) begin
      if (rst)         r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + DIV_W'(1);
   end

   assign w_at_vote = w_tick && (r_samp == 4'd9);
   assign w_vote    = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

`ifdef UART_RX_PARITY_EN
   logic r_par_err, r_parity_err;
   assign w_par_bad = r_par_err;
`else
   assign w_par_bad = 1'b0;
`endif

   assign w_push = (r_state == S_STOP) && w_at_vote && w_vote && !w_par_bad;

   // Frame FSM; the sample counter is re-phased on each start edge
   always_ff @(posedge clk100) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_samp       <= 4'd0;
         r_s7         <= 1'b1;
         r_s8         <= 1'b1;
         r_bit_idx    <= 3'd0;
         r_shift      <= 8'h00;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         if (w_tick) begin
            r_samp <= r_samp + 4'd1;
            if (r_samp == 4'd7) r_s7 <= r_rxs;
            if (r_samp == 4'd8) r_s8 <= r_rxs;
         end
         case (r_state)
            S_IDLE: begin
               if (!r_rxs) begin
                  r_samp  <= 4'd0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_at_vote) begin
                  if (w_vote) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state   <= S_DATA;
                     r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                     r_par_err <= 1'b0;
`endif
                  end
               end
            end
            S_DATA: begin
               if (w_at_vote) begin
                  r_shift[r_bit_idx] <= w_vote;
                  r_bit_idx          <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_at_vote) begin
                  if (w_vote != (^r_shift)) r_par_err <= 1'b1;
                  r_state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (w_at_vote) begin
                  if (w_vote) begin
`ifdef UART_RX_PARITY_EN
                     if (r_par_err) r_parity_err <= 1'b1;
`endif
                     r_state <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (r_rxs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_empty     = (r_fill == '0);
   assign w_full      = (r_fill == FILL_W'(FIFO_DEPTH));
   assign w_pop       = bus.rd_en && !w_empty;
   assign w_wr        = w_push && (!w_full || w_pop);
   assign w_rptr_next = r_rptr + (AW+1)'(1);

   always_comb begin
      w_fill_next = r_fill;
      if (w_wr && !w_pop)      w_fill_next = r_fill + FILL_W'(1);
      else if (!w_wr && w_pop) w_fill_next = r_fill - FILL_W'(1);
   end

   always_ff @(posedge clk100) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
   end

   // FIFO control; the head register follows the read pointer (fall-through)
   always_ff @(posedge clk100) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_fill     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
         r_rx_data  <= 8'h00;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop) r_rptr <= w_rptr_next;
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
         r_fill  <= w_fill_next;
         r_valid <= (w_fill_next != '0);
         if (w_wr && w_empty)
            r_rx_data <= r_shift;
         else if (w_pop && (r_fill > FILL_W'(1)))
            r_rx_data <= r_mem[w_rptr_next[AW-1:0]];
         else if (w_pop && w_wr)
            r_rx_data <= r_shift;
      end
   end

   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_valid;
   assign bus.fill      = r_fill;
   assign bus.frame_err = r_frame_err;
   assign bus.overflow  = r_overflow;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = r_parity_err;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit (DIV=1), FIFO_DEPTH=16.
module tb_uart_rx_fifo;
   logic clk100 = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_ferr   = 0;
   int   n_perr   = 0;
   int   f0, p0;

   always #5 clk100 = ~clk100;

   uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus ();

   uart_rx_fifo #(
      .CLK_HZ    (16_000_000),
      .BAUD      (1_000_000),
      .FIFO_DEPTH(16)
   ) dut (
      .clk100(clk100),
      .rst   (rst),
      .bus   (bus)
   );

   // Error pulses are counted per high cycle, so a wide pulse shows up as >1
   always @(negedge clk100) begin
      if (bus.frame_err)  n_ferr++;
      if (bus.parity_err) n_perr++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk100);
      #1;
   endtask

   // Start, 8 data bits, optional parity, stop; optionally pops on the stop-vote clock
   task automatic send_bits(input logic [7:0] d, input logic stopv, input logic parv,
                            input bit pop_at_stop);
      bus.rxd = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = d[i];
         tick(16);
      end
`ifdef UART_RX_PARITY_EN
      bus.rxd = parv;
      tick(16);
`else
      if (parv) bus.rxd = 1'b0;
`endif
      bus.rxd = stopv;
      if (pop_at_stop) begin
         tick(12);
         bus.rd_en = 1'b1;
         tick(1);
         bus.rd_en = 1'b0;
         tick(3);
      end else begin
         tick(16);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_bits(d, 1'b1, ^d, 1'b0);
      bus.rxd = 1'b1;
      tick(4);
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      tick(1);
      bus.rd_en = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      rst       = 1'b1;
      bus.rxd   = 1'b1;
      bus.rd_en = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("rst_data",     32'(bus.rx_data),    32'h00);
      chk("rst_valid",    32'(bus.rx_valid),   32'd0);
      chk("rst_fill",     32'(bus.fill),       32'd0);
      chk("rst_ferr",     32'(bus.frame_err),  32'd0);
      chk("rst_perr",     32'(bus.parity_err), 32'd0);
      chk("rst_ovf",      32'(bus.overflow),   32'd0);

      // Single byte and pop
      send_byte(8'hFA);
      chk("fa_valid", 32'(bus.rx_valid), 32'd1);
      chk("fa_data",  32'(bus.rx_data),  32'hFA);
      chk("fa_fill",  32'(bus.fill),     32'd1);
      chk("fa_ferr",  32'(n_ferr),       32'd0);
      pop();
      chk("fa_pop_fill",  32'(bus.fill),     32'd0);
      chk("fa_pop_valid", 32'(bus.rx_valid), 32'd0);
      chk("fa_pop_hold",  32'(bus.rx_data),  32'hFA);
      pop();
      chk("empty_pop_fill", 32'(bus.fill), 32'd0);

      // Start-bit glitch rejected
      bus.rxd = 1'b0;
      tick(4);
      bus.rxd = 1'b1;
      tick(40);
      chk("glitch_fill", 32'(bus.fill), 32'd0);
      chk("glitch_ferr", 32'(n_ferr),   32'd0);
      send_byte(8'h19);
      chk("g19_data", 32'(bus.rx_data), 32'h19);
      chk("g19_fill", 32'(bus.fill),    32'd1);
      pop();

      // Framing error followed by a held-low line
      f0 = n_ferr;
      send_bits(8'h1A, 1'b0, ^8'h1A, 1'b0);
      tick(40);
      chk("ferr_pulse", 32'(n_ferr - f0), 32'd1);
      chk("ferr_fill",  32'(bus.fill),    32'd0);
      bus.rxd = 1'b1;
      tick(20);
      chk("break_no_restart", 32'(n_ferr - f0), 32'd1);
      chk("break_fill",       32'(bus.fill),    32'd0);
      send_byte(8'hFF);
      chk("ff_data", 32'(bus.rx_data), 32'hFF);
      chk("ff_fill", 32'(bus.fill),    32'd1);
      pop();

      // Overflow and ordering
      for (int i = 0; i <= 16; i++) send_byte(8'(i));
      chk("ovf_fill", 32'(bus.fill),     32'd16);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_pop%0d", i), 32'(bus.rx_data), 32'(i));
         pop();
      end
      chk("ovf_drained", 32'(bus.fill),     32'd0);
      chk("ovf_valid",   32'(bus.rx_valid), 32'd0);
      chk("ovf_sticky",  32'(bus.overflow), 32'd1);

      // Push and pop on the same clock while full
      pulse_rst();
      chk("ovf_rst", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
      chk("full_fill", 32'(bus.fill),     32'd16);
      chk("full_ovf",  32'(bus.overflow), 32'd0);
      send_bits(8'h50, 1'b1, ^8'h50, 1'b1);
      bus.rxd = 1'b1;
      tick(4);
      chk("pp_fill", 32'(bus.fill),     32'd16);
      chk("pp_ovf",  32'(bus.overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("pp_pop%0d", i), 32'(bus.rx_data), 32'h41 + 32'(i));
         pop();
      end
      chk("pp_drained", 32'(bus.fill),    32'd0);
      chk("pp_hold",    32'(bus.rx_data), 32'h50);

      // Reset mid-frame after data bit 3
      send_byte(8'h33);
      b = 8'h55;
      bus.rxd = 1'b0;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         bus.rxd = b[i];
         tick(16);
      end
      bus.rxd = 1'b1;
      pulse_rst();
      chk("mid_rst_data",  32'(bus.rx_data),  32'h00);
      chk("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
      chk("mid_rst_fill",  32'(bus.fill),     32'd0);
      chk("mid_rst_ferr",  32'(bus.frame_err), 32'd0);
      f0 = n_ferr;
      tick(40);
      send_byte(8'h55);
      chk("r55_data", 32'(bus.rx_data), 32'h55);
      chk("r55_fill", 32'(bus.fill),    32'd1);
      chk("r55_ferr", 32'(n_ferr - f0), 32'd0);
      pop();

`ifdef UART_RX_PARITY_EN
      p0 = n_perr;
      send_bits(8'h03, 1'b1, 1'b1, 1'b0);
      bus.rxd = 1'b1;
      tick(4);
      chk("par_bad_pulse", 32'(n_perr - p0), 32'd1);
      chk("par_bad_fill",  32'(bus.fill),    32'd0);
      send_bits(8'h03, 1'b1, 1'b0, 1'b0);
      bus.rxd = 1'b1;
      tick(4);
      chk("par_ok_data",  32'(bus.rx_data),  32'h03);
      chk("par_ok_fill",  32'(bus.fill),     32'd1);
      chk("par_ok_pulse", 32'(n_perr - p0),  32'd1);
`else
      p0 = n_perr;
      chk("perr_tied", 32'(p0), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
